// File: rtl/seq_addsub_pkg.sv
// Shared types and sizing helpers for the multi-cycle adder/subtractor.
package seq_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int w, input int c);
        return (c < 1) ? 1 : w / c;
    endfunction

    // Counter width sized to hold 0..NCHUNK.
    function automatic int cnt_width(input int w, input int c);
        return $clog2(nchunk(w, c) + 1);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit gate-level ripple adder with B-invert for subtraction.
module addsub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK-1:0] bx;
    logic [CHUNK:0]   c;

    assign bx   = b ^ {CHUNK{sub}};
    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle two's-complement add/sub, CHUNK bits per cycle, with flags and
// optional signed saturation.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for operands, in_ready high
//   CALC    | one chunk per cycle, LSB chunk first, index k
//   DONE    | result and flags held until out_ready
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans,
    output logic             cout,
    output logic             v,
    output logic             z,
    output logic             n
);

    if (CHUNK < 1) begin : g_bad_chunk
        $error("seq_addsub: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("seq_addsub: WIDTH must be a multiple of CHUNK");
    end

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int KW     = cnt_width(WIDTH, CHUNK);
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    state_t           state;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] a_r, b_r, res;
    logic             sub_r, sat_r;

    logic [CHUNK-1:0] csum;
    logic             cco, cmsb, v_raw;
    logic [WIDTH-1:0] raw, fin;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_r[k*CHUNK +: CHUNK]),
        .b     (b_r[k*CHUNK +: CHUNK]),
        .sub   (sub_r),
        .cin   (carry),
        .sum   (csum),
        .cout  (cco),
        .c_msb (cmsb)
    );

    assign v_raw    = cmsb ^ cco;
    assign in_ready = (state == ST_IDLE) && !rst;

    // Full result as it will look once the current chunk is written back.
    always_comb begin
        raw = res;
        raw[k*CHUNK +: CHUNK] = csum;
        fin = raw;
        if (sat_r && v_raw) begin
            fin = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            k         <= '0;
            carry     <= 1'b0;
            res       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            sub_r     <= 1'b0;
            sat_r     <= 1'b0;
            out_valid <= 1'b0;
            ans       <= '0;
            cout      <= 1'b0;
            v         <= 1'b0;
            z         <= 1'b0;
            n         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        sub_r <= sub;
                        sat_r <= sat;
                        carry <= sub;
                        k     <= '0;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    res[k*CHUNK +: CHUNK] <= csum;
                    carry <= cco;
                    if (k == K_LAST) begin
                        ans       <= fin;
                        cout      <= cco;
                        v         <= v_raw;
                        z         <= (fin == '0);
                        n         <= fin[WIDTH-1];
                        out_valid <= 1'b1;
                        k         <= '0;
                        state     <= ST_DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub with an arithmetic reference model and a
// per-cycle scoreboard compare.
module tb_seq_addsub;

    typedef struct packed {
        logic [31:0] ans;
        logic        cout, v, z, n;
    } exp_t;

    typedef struct packed {
        logic [31:0] a, b;
        logic        sub, sat;
        logic [31:0] ans;
        logic        cout, v, z, n;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sub, sat, out_valid, out_ready;
    logic [31:0] a, b, ans;
    logic        cout, v, z, n;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] a1, b1, ans1;
    logic        cout1, v1, z1, n1;

    int passed = 0;
    int total  = 0;

    exp_t        sbq[$];
    logic        busy = 1'b0;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .ans(ans), .cout(cout), .v(v), .z(z), .n(n)
    );

    seq_addsub #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .sub(1'b0), .sat(1'b0),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .ans(ans1), .cout(cout1), .v(v1), .z(z1), .n(n1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic, overflow judged by range.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic ms, input logic mt);
        exp_t        e;
        logic [32:0] full;
        longint      sr;
        full = ms ? ({1'b0, ma} + {1'b0, ~mb} + 33'd1) : ({1'b0, ma} + {1'b0, mb});
        sr   = ms ? (longint'($signed(ma)) - longint'($signed(mb)))
                  : (longint'($signed(ma)) + longint'($signed(mb)));
        e.cout = full[32];
        e.v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.ans  = full[31:0];
        if (mt && e.v) e.ans = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        e.z = (e.ans == 32'h0);
        e.n = e.ans[31];
        return e;
    endfunction

    // Scoreboard: inputs only change just after posedge, so negedge values
    // equal what the DUT samples on the next edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
            sbq.delete();
            busy = 1'b0;
        end else begin
            chk("mon_in_ready", {31'b0, in_ready}, {31'b0, !busy});
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("mon_unexpected_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    chk("mon_ans", ans, sbq[0].ans);
                    chk("mon_flags", {28'b0, cout, v, z, n},
                        {28'b0, sbq[0].cout, sbq[0].v, sbq[0].z, sbq[0].n});
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        busy = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back(model(a, b, sub, sat));
                busy = 1'b1;
            end
        end
    end

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb,
                         input logic ts, input logic tt);
        logic acc;
        acc = 1'b0;
        a = ta; b = tb; sub = ts; sat = tt; in_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    vec_t vecs[8];
    exp_t me;
    int   lat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0021, 32'h0000_0022, 1'b0, 1'b0, 32'h0000_0043, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h336F_B7E5, 32'h336F_B7E5, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'hF1E3_B1BF, 32'h00FB_DBFD, 1'b0, 1'b0, 32'hF2DF_8DBC, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_ans", ans, 32'd0);
        chk("reset_flags", {28'b0, cout, v, z, n}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

        foreach (vecs[i]) begin
            me = model(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sat);
            chk($sformatf("model_ans_%0d", i), me.ans, vecs[i].ans);
            chk($sformatf("model_flags_%0d", i), {28'b0, me.cout, me.v, me.z, me.n},
                {28'b0, vecs[i].cout, vecs[i].v, vecs[i].z, vecs[i].n});
            issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sat);
            wait_result(lat);
            chk($sformatf("latency_%0d", i), lat, 32'd4);
            chk($sformatf("ans_%0d", i), ans, vecs[i].ans);
            chk($sformatf("cout_%0d", i), {31'b0, cout}, {31'b0, vecs[i].cout});
            chk($sformatf("v_%0d", i), {31'b0, v}, {31'b0, vecs[i].v});
            chk($sformatf("z_%0d", i), {31'b0, z}, {31'b0, vecs[i].z});
            chk($sformatf("n_%0d", i), {31'b0, n}, {31'b0, vecs[i].n});
            handoff();
        end

        // Single-cycle configuration
        a1 = 32'h21; b1 = 32'h22; in_valid1 = 1'b1;
        chk("c32_in_ready", {31'b0, in_ready1}, 32'd1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("c32_out_valid_early", {31'b0, out_valid1}, 32'd0);
        @(posedge clk); #1;
        chk("c32_latency1_out_valid", {31'b0, out_valid1}, 32'd1);
        chk("c32_ans", ans1, 32'h43);
        chk("c32_flags", {28'b0, cout1, v1, z1, n1}, 32'd0);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        chk("c32_out_valid_after_handoff", {31'b0, out_valid1}, 32'd0);

        // Backpressure with competing in_valid
        issue(32'h21, 32'h22, 1'b0, 1'b0);
        wait_result(lat);
        chk("bp_latency", lat, 32'd4);
        a = 32'h1; b = 32'h1; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_ans_stable", ans, 32'h43);
            chk("bp_flags_stable", {28'b0, cout, v, z, n}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(lat);
        chk("bp_next_latency", lat, 32'd4);
        chk("bp_next_ans", ans, 32'h2);
        handoff();

        // Reset while in CALC at k=2
        issue(32'h10, 32'h20, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_ans", ans, 32'd0);
        chk("rst_mid_flags", {28'b0, cout, v, z, n}, 32'd0);
        chk("rst_mid_in_ready_after", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("rst_mid_no_result", {31'b0, out_valid}, 32'd0);
        end
        issue(vecs[6].a, vecs[6].b, vecs[6].sub, vecs[6].sat);
        wait_result(lat);
        chk("rst_after_latency", lat, 32'd4);
        chk("rst_after_ans", ans, vecs[6].ans);
        handoff();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
